// File: rtl/mips_pkg.sv
// Shared MIPS pipeline encodings and widths.
// Used by the memory stage and its lane aligner.
package mips_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    LD_LW  = 3'd0,
    LD_LH  = 3'd1,
    LD_LHU = 3'd2,
    LD_LB  = 3'd3,
    LD_LBU = 3'd4
  } load_t;

  typedef enum logic [1:0] {
    ST_SW = 2'd0,
    ST_SH = 2'd1,
    ST_SB = 2'd2
  } store_t;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'd0,
    BR_BNE  = 3'd1,
    BR_BGEZ = 3'd2,
    BR_BGTZ = 3'd3,
    BR_BLEZ = 3'd4,
    BR_BLTZ = 3'd5
  } branch_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores, extraction and
// extension for loads, and the misalign check.
module mem_lane_align
  import mips_pkg::*;
(
  input  logic [1:0]        addr_lo,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [2:0]        load_type,
  input  logic [1:0]        store_type,
  input  logic [WORD_W-1:0] st_data,
  input  logic [WORD_W-1:0] rd_data,
  output logic [3:0]        be,
  output logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] ld_data,
  output logic              misalign
);

  logic        sz_w;
  logic        sz_h;
  logic        sz_b;
  logic [15:0] half;
  logic [7:0]  bsel;

  // Decode access size and flag misaligned accesses
  always_comb begin
    sz_w = 1'b0;
    sz_h = 1'b0;
    sz_b = 1'b0;
    if (is_load) begin
      case (load_type)
        LD_LH, LD_LHU: sz_h = 1'b1;
        LD_LB, LD_LBU: sz_b = 1'b1;
        default:       sz_w = 1'b1;
      endcase
    end else begin
      case (store_type)
        ST_SH:   sz_h = 1'b1;
        ST_SB:   sz_b = 1'b1;
        default: sz_w = 1'b1;
      endcase
    end
    misalign = (is_load | is_store) &
               ((sz_w & (|addr_lo)) |
                (sz_h & addr_lo[0]));
  end

  // Store byte enables and replicated write data
  always_comb begin
    be    = 4'b1111;
    wdata = st_data;
    if (is_store) begin
      unique case (1'b1)
        sz_h: begin
          be    = 4'b0011 << {addr_lo[1], 1'b0};
          wdata = {2{st_data[15:0]}};
        end
        sz_b: begin
          be    = 4'b0001 << addr_lo;
          wdata = {4{st_data[7:0]}};
        end
        default: ;
      endcase
    end
  end

  // Load lane select and sign/zero extension
  always_comb begin
    half = addr_lo[1] ? rd_data[31:16] : rd_data[15:0];
    bsel = rd_data[{addr_lo, 3'b000} +: 8];
    case (load_type)
      LD_LH:   ld_data = {{16{half[15]}}, half};
      LD_LHU:  ld_data = {16'h0, half};
      LD_LB:   ld_data = {{24{bsel[7]}}, bsel};
      LD_LBU:  ld_data = {24'h0, bsel};
      default: ld_data = rd_data;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: data-memory access FSM,
// branch/jump resolution and the MEM/WB register.
module mem_stage
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] ex_mem_alu_out,
  input  logic [WORD_W-1:0] ex_mem_reg_b_data,
  input  logic [4:0]        ex_mem_rd,
  input  logic              ex_mem_ctrl_reg_write,
  input  logic              ex_mem_ctrl_mem_to_reg,
  input  logic              ex_mem_ctrl_mem_write,
  input  logic [2:0]        ex_mem_ctrl_load_type,
  input  logic [1:0]        ex_mem_ctrl_store_type,
  input  logic              ex_mem_ctrl_branch,
  input  logic              ex_mem_ctrl_jump,
  input  logic              ex_mem_ctrl_jump_reg,
  input  logic [2:0]        ex_mem_ctrl_branch_type,
  input  logic              ex_mem_alu_beq_sig,
  input  logic              ex_mem_alu_bne_sig,
  input  logic              ex_mem_alu_bgez_sig,
  input  logic              ex_mem_alu_bgtz_sig,
  input  logic              ex_mem_alu_blez_sig,
  input  logic              ex_mem_alu_bltz_sig,
  input  logic [WORD_W-1:0] ex_mem_pc_branch,
  input  logic [WORD_W-1:0] ex_mem_pc_jump,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [WORD_W-1:0] dmem_wdata,
  input  logic [WORD_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              mem_stall,
  output logic              mem_misalign,
  output logic              pc_redirect,
  output logic [WORD_W-1:0] pc_target,
  output logic              flush_ex,
  output logic              mem_wb_ctrl_reg_write,
  output logic              mem_wb_ctrl_mem_to_reg,
  output logic [4:0]        mem_wb_rd,
  output logic [WORD_W-1:0] mem_wb_data
);

  mem_state_t        state_q;
  mem_state_t        state_d;
  logic              is_load;
  logic              is_store;
  logic              mem_op;
  logic              mis_c;
  logic              req_c;
  logic [3:0]        be_c;
  logic [WORD_W-1:0] wdata_c;
  logic [WORD_W-1:0] ld_c;
  logic [ADDR_W-1:0] addr_c;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic [WORD_W-1:0] wdata_q;
  logic [7:0]        sig;
  logic              taken;

  assign is_load  = ex_mem_ctrl_mem_to_reg;
  assign is_store = ex_mem_ctrl_mem_write & ~is_load;
  assign mem_op   = is_load | is_store;
  assign req_c    = mem_op & ~mis_c;
  assign addr_c   = {ex_mem_alu_out[ADDR_W-1:2], 2'b00};

  mem_lane_align u_align (
    .addr_lo    (ex_mem_alu_out[1:0]),
    .is_load    (is_load),
    .is_store   (is_store),
    .load_type  (ex_mem_ctrl_load_type),
    .store_type (ex_mem_ctrl_store_type),
    .st_data    (ex_mem_reg_b_data),
    .rd_data    (dmem_rdata),
    .be         (be_c),
    .wdata      (wdata_c),
    .ld_data    (ld_c),
    .misalign   (mis_c)
  );

  // FSM state and request snapshot held during WAIT
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && req_c && !dmem_ack) begin
        we_q    <= is_store;
        addr_q  <= addr_c;
        be_q    <= be_c;
        wdata_q <= wdata_c;
      end
    end
  end

  // Next state, memory port drive and stall
  always_comb begin
    state_d    = state_q;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = addr_c;
    dmem_be    = be_c;
    dmem_wdata = wdata_c;
    unique case (state_q)
      S_IDLE: begin
        if (req_c) begin
          dmem_req = 1'b1;
          dmem_we  = is_store;
          if (!dmem_ack) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        dmem_req   = 1'b1;
        dmem_we    = we_q;
        dmem_addr  = addr_q;
        dmem_be    = be_q;
        dmem_wdata = wdata_q;
        if (dmem_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (rst) begin
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      state_d  = S_IDLE;
    end
    mem_stall = ~rst & ~dmem_ack &
                (req_c | (state_q == S_WAIT));
    mem_misalign = ~rst & mis_c;
  end

  // Branch condition select and redirect
  always_comb begin
    sig = {2'b00,
           ex_mem_alu_bltz_sig,
           ex_mem_alu_blez_sig,
           ex_mem_alu_bgtz_sig,
           ex_mem_alu_bgez_sig,
           ex_mem_alu_bne_sig,
           ex_mem_alu_beq_sig};
    taken = ex_mem_ctrl_branch &
            sig[ex_mem_ctrl_branch_type];
    pc_redirect = ~rst & (taken |
                  ex_mem_ctrl_jump |
                  ex_mem_ctrl_jump_reg);
    pc_target = (ex_mem_ctrl_jump |
                 ex_mem_ctrl_jump_reg) ?
                ex_mem_pc_jump : ex_mem_pc_branch;
    flush_ex = pc_redirect;
  end

  // MEM/WB register with bubble on stall/misalign
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_wb_ctrl_reg_write  <= 1'b0;
      mem_wb_ctrl_mem_to_reg <= 1'b0;
      mem_wb_rd              <= '0;
      mem_wb_data            <= '0;
    end else if (mem_stall || mis_c) begin
      mem_wb_ctrl_reg_write  <= 1'b0;
      mem_wb_ctrl_mem_to_reg <= 1'b0;
    end else begin
      mem_wb_ctrl_reg_write  <= ex_mem_ctrl_reg_write;
      mem_wb_ctrl_mem_to_reg <= ex_mem_ctrl_mem_to_reg;
      mem_wb_rd              <= ex_mem_rd;
      mem_wb_data            <= is_load ? ld_c :
                                ex_mem_alu_out;
    end
  end

endmodule
